// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the kNN core: sequencer state encoding and the
// default widths used by the list controller, the list chain and the top.
//   KnnDataW   distance width
//   KnnLabelW  label width
//   KnnCoordW  unsigned coordinate width per axis
//   KnnIdxW    point index / count width
// ---------------------------------------------------------------------------
package knn_pkg;

    localparam int unsigned KnnDataW  = 32;
    localparam int unsigned KnnLabelW = 8;
    localparam int unsigned KnnCoordW = 15;
    localparam int unsigned KnnIdxW   = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StFetch = 3'd2,
        StCalc  = 3'd3,
        StPush  = 3'd4,
        StDone  = 3'd5
    } knn_state_e;

endpackage

// File: rtl/knn_sq_dist.sv
// ---------------------------------------------------------------------------
// knn_sq_dist
// Purely combinational squared Euclidean distance between two 2-D points.
// Ports:
//   i_ax, i_ay  point A coordinates (unsigned)
//   i_bx, i_by  point B coordinates (unsigned)
//   o_dx, o_dy  absolute per-axis differences
//   o_dist      dx*dx + dy*dy, zero-extended to DATA_W
// DATA_W must be at least 2*COORD_W+1 for the result to be exact.
// ---------------------------------------------------------------------------
module knn_sq_dist #(
    parameter int unsigned COORD_W = 15,
    parameter int unsigned DATA_W  = 32
) (
    input  logic [COORD_W-1:0] i_ax,
    input  logic [COORD_W-1:0] i_ay,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    output logic [COORD_W-1:0] o_dx,
    output logic [COORD_W-1:0] o_dy,
    output logic [DATA_W-1:0]  o_dist
);

    logic [2*COORD_W-1:0] w_sq_x;
    logic [2*COORD_W-1:0] w_sq_y;
    logic [2*COORD_W:0]   w_sum;

    assign o_dx = (i_ax >= i_bx) ? (i_ax - i_bx) : (i_bx - i_ax);
    assign o_dy = (i_ay >= i_by) ? (i_ay - i_by) : (i_by - i_ay);

    // Operands widened first so the products are full 2*COORD_W bits.
    assign w_sq_x = {{COORD_W{1'b0}}, o_dx} * {{COORD_W{1'b0}}, o_dx};
    assign w_sq_y = {{COORD_W{1'b0}}, o_dy} * {{COORD_W{1'b0}}, o_dy};

    // One extra bit holds the carry of the sum, so it can never overflow.
    assign w_sum  = {1'b0, w_sq_x} + {1'b0, w_sq_y};
    assign o_dist = DATA_W'(w_sum);

endmodule

// File: rtl/knn_list_ctrl.sv
// ---------------------------------------------------------------------------
// knn_list_ctrl
// Sequencer for the kNN sorted-neighbour list. On an accepted start it
// clears the list, fetches every dataset point over a req/ack port, computes
// its squared distance to the test point and presents each (distance, label)
// candidate to the list with a one-cycle valid pulse, then pulses done.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_start                      start request (ignored while busy / in DONE)
//   i_n_points, i_test_x/y       search parameters, latched on accepted start
//   o_pt_req, o_pt_idx           point fetch request and index
//   i_pt_ack, i_pt_x/y, i_pt_label  fetch response (may ack in request cycle)
//   o_list_clear                 one-cycle list re-initialisation pulse
//   o_list_start                 list enable level (equals busy)
//   o_list_valid                 one-cycle candidate strobe
//   o_dist_candidate             registered candidate distance
//   o_label_candidate            registered candidate label
//   o_busy, o_done               busy level, one-cycle completion pulse
// ---------------------------------------------------------------------------
module knn_list_ctrl
    import knn_pkg::*;
#(
    parameter int unsigned DATA_W  = KnnDataW,
    parameter int unsigned LABEL   = KnnLabelW,
    parameter int unsigned COORD_W = KnnCoordW,
    parameter int unsigned IDX_W   = KnnIdxW
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [IDX_W-1:0]   i_n_points,
    input  logic [COORD_W-1:0] i_test_x,
    input  logic [COORD_W-1:0] i_test_y,
    output logic               o_pt_req,
    output logic [IDX_W-1:0]   o_pt_idx,
    input  logic               i_pt_ack,
    input  logic [COORD_W-1:0] i_pt_x,
    input  logic [COORD_W-1:0] i_pt_y,
    input  logic [LABEL-1:0]   i_pt_label,
    output logic               o_list_clear,
    output logic               o_list_start,
    output logic               o_list_valid,
    output logic [DATA_W-1:0]  o_dist_candidate,
    output logic [LABEL-1:0]   o_label_candidate,
    output logic               o_busy,
    output logic               o_done
);

    if (DATA_W < 2 * COORD_W + 1) begin : g_param_check
        $error("knn_list_ctrl: DATA_W must be at least 2*COORD_W+1");
    end

    knn_state_e         r_state;
    logic [IDX_W-1:0]   r_n_points;
    logic [COORD_W-1:0] r_test_x;
    logic [COORD_W-1:0] r_test_y;
    logic [COORD_W-1:0] r_pt_x;
    logic [COORD_W-1:0] r_pt_y;
    logic [LABEL-1:0]   r_pt_label;
    logic [IDX_W-1:0]   r_pt_idx;
    logic               r_pt_req;
    logic               r_list_clear;
    logic               r_list_valid;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_dist;
    logic [LABEL-1:0]   r_label;

    logic [IDX_W-1:0]   w_idx_inc;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [DATA_W-1:0]  w_dist;
    logic               w_unused_diff;

    // The fetched point is captured raw; its distance to the latched test
    // point is evaluated in CALC, giving the same result as capturing the
    // absolute differences at ack time.
    knn_sq_dist #(
        .COORD_W (COORD_W),
        .DATA_W  (DATA_W)
    ) u_sq_dist (
        .i_ax   (r_pt_x),
        .i_ay   (r_pt_y),
        .i_bx   (r_test_x),
        .i_by   (r_test_y),
        .o_dx   (w_dx),
        .o_dy   (w_dy),
        .o_dist (w_dist)
    );

    // Per-axis differences are not needed by this 2-D sequencer.
    assign w_unused_diff = ^{w_dx, w_dy};

    // Termination compares the incremented index at IDX_W bits, so
    // n_points = 2^IDX_W-1 ends before any wrap.
    assign w_idx_inc = r_pt_idx + IDX_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_n_points   <= '0;
            r_test_x     <= '0;
            r_test_y     <= '0;
            r_pt_x       <= '0;
            r_pt_y       <= '0;
            r_pt_label   <= '0;
            r_pt_idx     <= '0;
            r_pt_req     <= 1'b0;
            r_list_clear <= 1'b0;
            r_list_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dist       <= '0;
            r_label      <= '0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one state.
            r_list_clear <= 1'b0;
            r_list_valid <= 1'b0;
            r_done       <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_n_points   <= i_n_points;
                        r_test_x     <= i_test_x;
                        r_test_y     <= i_test_y;
                        r_pt_idx     <= '0;
                        r_list_clear <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= StClear;
                    end
                end

                StClear: begin
                    if (r_n_points == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_pt_req <= 1'b1;
                        r_state  <= StFetch;
                    end
                end

                StFetch: begin
                    if (i_pt_ack) begin
                        r_pt_x     <= i_pt_x;
                        r_pt_y     <= i_pt_y;
                        r_pt_label <= i_pt_label;
                        r_pt_req   <= 1'b0;
                        r_state    <= StCalc;
                    end
                end

                StCalc: begin
                    r_dist       <= w_dist;
                    r_label      <= r_pt_label;
                    r_list_valid <= 1'b1;
                    r_state      <= StPush;
                end

                StPush: begin
                    r_pt_idx <= w_idx_inc;
                    if (w_idx_inc == r_n_points) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_pt_req <= 1'b1;
                        r_state  <= StFetch;
                    end
                end

                StDone: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_pt_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign o_pt_req          = r_pt_req;
    assign o_pt_idx          = r_pt_idx;
    assign o_list_clear      = r_list_clear;
    assign o_list_start      = r_busy;
    assign o_list_valid      = r_list_valid;
    assign o_dist_candidate  = r_dist;
    assign o_label_candidate = r_label;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

endmodule

// File: tb/tb_knn_list_ctrl.sv
// ---------------------------------------------------------------------------
// tb_knn_list_ctrl
// Self-checking bench for knn_list_ctrl: a table of single-point searches,
// hand-written multi-cycle sequences and randomised searches, all checked
// against an event-level model (cycle of each candidate, distance, done).
// ---------------------------------------------------------------------------
module tb_knn_list_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LABEL   = 8;
    localparam int unsigned COORD_W = 15;
    localparam int unsigned IDX_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic [IDX_W-1:0]   i_n_points;
    logic [COORD_W-1:0] i_test_x;
    logic [COORD_W-1:0] i_test_y;
    logic               o_pt_req;
    logic [IDX_W-1:0]   o_pt_idx;
    logic               i_pt_ack;
    logic [COORD_W-1:0] i_pt_x;
    logic [COORD_W-1:0] i_pt_y;
    logic [LABEL-1:0]   i_pt_label;
    logic               o_list_clear;
    logic               o_list_start;
    logic               o_list_valid;
    logic [DATA_W-1:0]  o_dist_candidate;
    logic [LABEL-1:0]   o_label_candidate;
    logic               o_busy;
    logic               o_done;

    int checks   = 0;
    int failures = 0;

    // Dataset and per-point ack delay seen by the responder.
    int px [16];
    int py [16];
    int lab[16];
    int dly[16];

    // Results of the most recent search.
    int     last_done;
    int     last_req_n;
    int     last_vc[16];
    longint last_vd[16];
    int     last_vl[16];

    typedef struct {
        int     tx;
        int     ty;
        int     px;
        int     py;
        int     lab;
        longint exp_dist;
    } vec_t;

    vec_t tbl[8];

    knn_list_ctrl #(
        .DATA_W  (DATA_W),
        .LABEL   (LABEL),
        .COORD_W (COORD_W),
        .IDX_W   (IDX_W)
    ) u_dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (i_start),
        .i_n_points        (i_n_points),
        .i_test_x          (i_test_x),
        .i_test_y          (i_test_y),
        .o_pt_req          (o_pt_req),
        .o_pt_idx          (o_pt_idx),
        .i_pt_ack          (i_pt_ack),
        .i_pt_x            (i_pt_x),
        .i_pt_y            (i_pt_y),
        .i_pt_label        (i_pt_label),
        .o_list_clear      (o_list_clear),
        .o_list_start      (o_list_start),
        .o_list_valid      (o_list_valid),
        .o_dist_candidate  (o_dist_candidate),
        .o_label_candidate (o_label_candidate),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sq_dist(input int ax, input int ay, input int bx, input int by);
        longint dx;
        longint dy;
        dx = (ax >= bx) ? longint'(ax - bx) : longint'(bx - ax);
        dy = (ay >= by) ? longint'(ay - by) : longint'(by - ay);
        return dx * dx + dy * dy;
    endfunction

    // Idle cycles: nothing may be active.
    task automatic step_idle(input int k, input string name);
        int act;
        act = 0;
        repeat (k) begin
            @(posedge clk);
            #1;
            i_start  = 1'b0;
            i_pt_ack = 1'b0;
            if (o_busy || o_list_start || o_list_clear || o_pt_req || o_list_valid || o_done)
                act++;
        end
        chk(name, act, 0);
    endtask

    // Presents start in the current cycle (cycle 0) and follows the search to
    // done, answering fetches with px/py/lab after dly[i] wait cycles. Returns
    // in the done cycle. Expected timing: candidate i appears in cycle
    // 1 + sum_{k<=i}(3+dly[k]); done in cycle 2 + sum_{k<n}(3+dly[k]).
    task automatic run_search(input int n, input int tx, input int ty,
                              input bit inj_fetch, input bit inj_done, input string tag);
        int c, clr_c, clr_n, req_n, busy_n, acks, wait_n, v;
        int bad_idx, bad_ls, consec, busy_at_done, exp_acc, exp_done, budget;
        bit prev_v, injected;
        exp_done = 2;
        for (int i = 0; i < n; i++) exp_done += 3 + dly[i];
        budget = exp_done + 20;
        i_n_points = IDX_W'(n);
        i_test_x   = COORD_W'(tx);
        i_test_y   = COORD_W'(ty);
        i_start    = 1'b1;
        last_done = -1; clr_c = -1; clr_n = 0; req_n = 0; busy_n = 0; acks = 0;
        wait_n = 0; v = 0; bad_idx = 0; bad_ls = 0; consec = 0; busy_at_done = -1;
        prev_v = 1'b0; injected = 1'b0;
        for (c = 1; c <= budget && last_done < 0; c++) begin
            @(posedge clk);
            #1;
            i_start    = 1'b0;
            i_pt_ack   = 1'b0;
            i_pt_x     = COORD_W'($urandom);
            i_pt_y     = COORD_W'($urandom);
            i_pt_label = LABEL'($urandom);
            if (inj_fetch && !injected && o_pt_req) begin
                i_start  = 1'b1;
                injected = 1'b1;
            end
            if (o_list_start !== o_busy) bad_ls++;
            if (o_busy) busy_n++;
            if (o_list_clear) begin
                clr_n++;
                clr_c = c;
            end
            if (o_list_valid) begin
                if (prev_v) consec++;
                if (v < 16) begin
                    last_vc[v] = c;
                    last_vd[v] = longint'(o_dist_candidate);
                    last_vl[v] = int'(o_label_candidate);
                end
                v++;
            end
            prev_v = o_list_valid;
            if (o_done) begin
                last_done    = c;
                busy_at_done = int'(o_busy);
                if (inj_done) i_start = 1'b1;
            end
            if (o_pt_req) begin
                req_n++;
                if (int'(o_pt_idx) != acks) bad_idx++;
                if (acks < 16 && wait_n >= dly[acks]) begin
                    i_pt_ack   = 1'b1;
                    i_pt_x     = COORD_W'(px[acks]);
                    i_pt_y     = COORD_W'(py[acks]);
                    i_pt_label = LABEL'(lab[acks]);
                    acks++;
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end
        end
        last_req_n = req_n;
        chk({tag, ".done_cycle"}, last_done, exp_done);
        chk({tag, ".clear_cycle"}, clr_c, 1);
        chk({tag, ".clear_count"}, clr_n, 1);
        chk({tag, ".valid_count"}, v, n);
        chk({tag, ".busy_cycles"}, busy_n, exp_done - 1);
        chk({tag, ".busy_in_done"}, busy_at_done, 0);
        exp_acc = 0;
        for (int i = 0; i < n; i++) exp_acc += 1 + dly[i];
        chk({tag, ".req_cycles"}, req_n, exp_acc);
        chk({tag, ".pt_idx_errors"}, bad_idx, 0);
        chk({tag, ".list_start_errors"}, bad_ls, 0);
        chk({tag, ".valid_back_to_back"}, consec, 0);
        exp_acc = 1;
        for (int i = 0; i < n && i < v && i < 16; i++) begin
            exp_acc += 3 + dly[i];
            chk($sformatf("%s.valid%0d_cycle", tag, i), last_vc[i], exp_acc);
            chk($sformatf("%s.valid%0d_dist", tag, i), last_vd[i],
                sq_dist(px[i], py[i], tx, ty));
            chk($sformatf("%s.valid%0d_label", tag, i), last_vl[i], lab[i]);
        end
    endtask

    initial begin
        tbl[0] = '{tx: 0,     ty: 0,     px: 3,     py: 4,     lab: 1,   exp_dist: 25};
        tbl[1] = '{tx: 0,     ty: 0,     px: 1,     py: 1,     lab: 2,   exp_dist: 2};
        tbl[2] = '{tx: 0,     ty: 0,     px: 10,    py: 0,     lab: 3,   exp_dist: 100};
        tbl[3] = '{tx: 0,     ty: 0,     px: 32767, py: 32767, lab: 255, exp_dist: 2147352578};
        tbl[4] = '{tx: 32767, ty: 32767, px: 32767, py: 32767, lab: 7,   exp_dist: 0};
        tbl[5] = '{tx: 5,     ty: 9,     px: 2,     py: 13,    lab: 42,  exp_dist: 25};
        tbl[6] = '{tx: 100,   ty: 0,     px: 0,     py: 100,   lab: 9,   exp_dist: 20000};
        tbl[7] = '{tx: 32767, ty: 0,     px: 0,     py: 0,     lab: 128, exp_dist: 1073676289};

        for (int i = 0; i < 16; i++) begin
            px[i] = 0; py[i] = 0; lab[i] = 0; dly[i] = 0;
        end
        rst_n = 1'b0; i_start = 1'b1; i_n_points = 16'd5; i_test_x = '0; i_test_y = '0;
        i_pt_ack = 1'b0; i_pt_x = '0; i_pt_y = '0; i_pt_label = '0;

        // Reset held with start asserted: everything stays zero.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", longint'({o_pt_req, o_pt_idx, o_list_clear, o_list_start,
            o_list_valid, o_dist_candidate, o_label_candidate, o_busy, o_done}), 0);
        rst_n   = 1'b1;
        i_start = 1'b0;
        step_idle(4, "post_reset_quiet");

        // Table: single-point searches with known distances.
        for (int t = 0; t < 8; t++) begin
            px[0] = tbl[t].px; py[0] = tbl[t].py; lab[0] = tbl[t].lab; dly[0] = 0;
            run_search(1, tbl[t].tx, tbl[t].ty, 1'b0, 1'b0, $sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d.table_dist", t), last_vd[0], tbl[t].exp_dist);
            step_idle(1, $sformatf("tbl%0d.idle", t));
        end

        // Three points, immediate ack, fixed timeline.
        px[0] = 3;  py[0] = 4; lab[0] = 1;
        px[1] = 1;  py[1] = 1; lab[1] = 2;
        px[2] = 10; py[2] = 0; lab[2] = 3;
        for (int i = 0; i < 3; i++) dly[i] = 0;
        run_search(3, 0, 0, 1'b0, 1'b0, "three");
        chk("three.v0_cycle", last_vc[0], 4);
        chk("three.v1_cycle", last_vc[1], 7);
        chk("three.v2_cycle", last_vc[2], 10);
        chk("three.v0_dist", last_vd[0], 25);
        chk("three.v1_dist", last_vd[1], 2);
        chk("three.v2_dist", last_vd[2], 100);
        chk("three.v2_label", last_vl[2], 3);
        chk("three.done", last_done, 11);
        step_idle(2, "three.idle");

        // Empty dataset.
        run_search(0, 7, 7, 1'b0, 1'b0, "empty");
        chk("empty.done", last_done, 2);
        chk("empty.no_req", last_req_n, 0);
        step_idle(2, "empty.idle");

        // Ack delayed three cycles on point 1 of 2.
        px[0] = 3; py[0] = 4; lab[0] = 5; dly[0] = 0;
        px[1] = 6; py[1] = 8; lab[1] = 6; dly[1] = 3;
        run_search(2, 0, 0, 1'b0, 1'b0, "delay");
        chk("delay.done", last_done, 11);
        chk("delay.req_cycles", last_req_n, 5);
        chk("delay.v1_dist", last_vd[1], 100);
        step_idle(1, "delay.idle");

        // Start during FETCH and in DONE are ignored.
        dly[1] = 1;
        run_search(2, 1, 2, 1'b1, 1'b1, "ignore");
        step_idle(3, "ignore.after_done_quiet");

        // Start in the cycle right after DONE is accepted.
        dly[1] = 0;
        run_search(2, 100, 200, 1'b0, 1'b0, "b2b_a");
        step_idle(1, "b2b.gap");
        run_search(2, 300, 50, 1'b0, 1'b0, "b2b_b");
        step_idle(1, "b2b.idle");

        // Asynchronous reset mid-search aborts immediately.
        i_n_points = 16'd4; i_test_x = 15'd1; i_test_y = 15'd1; i_start = 1'b1;
        i_pt_ack = 1'b1; i_pt_x = 15'd20; i_pt_y = 15'd30; i_pt_label = 8'd9;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort.outputs", longint'({o_pt_req, o_pt_idx, o_list_clear, o_list_start,
            o_list_valid, o_dist_candidate, o_label_candidate, o_busy, o_done}), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        i_pt_ack = 1'b0;
        step_idle(2, "abort.idle");
        run_search(2, 0, 0, 1'b0, 1'b0, "after_abort");
        step_idle(1, "after_abort.idle");

        // Randomised searches against the model.
        for (int t = 0; t < 30; t++) begin
            int n, tx, ty;
            n  = int'($urandom_range(0, 6));
            tx = ($urandom_range(0, 3) == 0) ? 32767 : int'($urandom_range(0, 32767));
            ty = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 32767));
            for (int i = 0; i < n; i++) begin
                px[i]  = ($urandom_range(0, 4) == 0) ? 32767 : int'($urandom_range(0, 32767));
                py[i]  = int'($urandom_range(0, 32767));
                lab[i] = int'($urandom_range(0, 255));
                dly[i] = int'($urandom_range(0, 3));
            end
            run_search(n, tx, ty, 1'b0, 1'b0, $sformatf("rnd%0d", t));
            step_idle(1 + int'($urandom_range(0, 2)), $sformatf("rnd%0d.idle", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knn_list_ctrl.md
Name: knn_list_ctrl

Overview:
- Sequencer for the kNN sorted-neighbour list, which is a chain of list elements.
- On start it clears the list, then fetches each dataset point over a request/ack port and computes its squared Euclidean distance to the test point.
- It presents each (distance, label) candidate to the list with a one-cycle valid pulse, then signals done.
- Sits between the dataset memory / register bank and the list chain inside the kNN core.

Parameters:
- DATA_W, 32, distance width; must satisfy DATA_W >= 2*COORD_W+1 (elaboration-time check).
- LABEL, 8, label width.
- COORD_W, 15, unsigned coordinate width per axis.
- IDX_W, 16, point index / count width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a search; ignored while busy.
- n_points  in  IDX_W  number of dataset points; sampled on accepted start.
- test_x  in  COORD_W  test point X; sampled on accepted start.
- test_y  in  COORD_W  test point Y; sampled on accepted start.
- pt_req  out  1  fetch request; held until pt_ack.
- pt_idx  out  IDX_W  index of the point requested.
- pt_ack  in  1  data valid this cycle; may be asserted in the same cycle as pt_req.
- pt_x  in  COORD_W  dataset point X, valid with pt_ack.
- pt_y  in  COORD_W  dataset point Y, valid with pt_ack.
- pt_label  in  LABEL  dataset point label, valid with pt_ack.
- list_clear  out  1  one-cycle pulse; re-initialises the list elements to all-ones.
- list_start  out  1  list enable level; equals busy.
- list_valid  out  1  one-cycle candidate strobe.
- dist_candidate  out  DATA_W  candidate distance, registered.
- label_candidate  out  LABEL  candidate label, registered.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0; pt_idx=0; latched test point and count = 0.
  - Reset mid-search aborts immediately. The list contents are then undefined; the next search clears them.
- States:
  - IDLE
    - start=1: latch n_points, test_x, test_y; pt_idx<=0; go to CLEAR.
  - CLEAR (1 cycle)
    - list_clear=1, busy=1.
    - Go to DONE if latched n_points==0, else FETCH.
  - FETCH
    - pt_req=1, pt_idx=current index.
    - On pt_ack: capture abs(pt_x-test_x), abs(pt_y-test_y) and pt_label; go to CALC.
    - pt_req drops in the cycle after the ack.
  - CALC (1 cycle)
    - dist = dx*dx + dy*dy, zero-extended to DATA_W.
    - Never saturates: 2*COORD_W+1 bits always fits.
    - Register into dist_candidate; register the label into label_candidate; go to PUSH.
  - PUSH (1 cycle)
    - list_valid=1, with dist_candidate/label_candidate stable.
    - Increment pt_idx.
    - Go to DONE if incremented index == n_points, else FETCH.
  - DONE (1 cycle)
    - done=1; busy and list_start drop to 0 in this cycle; go to IDLE.
    - The list is readable from the following cycle.
- busy = list_start = 1 in CLEAR, FETCH, CALC, PUSH.
- list_valid is never high in two consecutive cycles. This gives the list one full cycle to register each insertion before the next compare.
- Latency with pt_ack in the first request cycle: 1 (CLEAR) + 3*N + 1 (DONE). N=0 gives 2 cycles from start acceptance to done.
- Wait states: each cycle without ack adds one FETCH cycle; pt_idx, pt_req and the outputs hold.
- start in DONE or while busy: ignored, no queuing. start in the cycle after DONE, i.e. back in IDLE, is accepted.
- n_points = 2^IDX_W-1: the index comparison uses the incremented value at IDX_W bits; no wrap occurs before termination.
- dist_candidate/label_candidate hold their last values outside PUSH.

Decomposition:
- Package knn_pkg:
  - state encoding (IDLE, CLEAR, FETCH, CALC, PUSH, DONE; 3-bit)
  - default DATA_W, LABEL, COORD_W, IDX_W constants, shared with the list chain and the top level.
- Sub-module knn_sq_dist:
  - purely combinational
  - inputs: two coordinate pairs
  - outputs: absolute differences and squared-sum distance
  - reused by future multi-dimensional variants.
- The FSM, counter and output registers stay in knn_list_ctrl.

Test Plan:
- Reset held low with start=1 -> all outputs 0, state IDLE; after release, no activity until start.
- Test point (0,0), n_points=3, points (3,4,L=1) (1,1,L=2) (10,0,L=3), immediate ack:
  - list_clear in cycle 1;
  - list_valid pulses in cycles 4, 7, 10 carrying 25/1, 2/2, 100/3;
  - done in cycle 11;
  - busy high for cycles 1-10.
- n_points=0 -> list_clear in cycle 1, done in cycle 2, no pt_req, no list_valid.
- Ack delayed 3 cycles on point 1 of 2 -> pt_req and pt_idx=1 held for 4 cycles; total latency 1+6+3+1=11; distances unaffected.
- Extreme coordinates: test=(0,0), point=(32767,32767) -> dist_candidate=2147352578, no overflow; test=(32767,32767) with the same point -> 0.
- start pulsed during FETCH, and again in the DONE cycle -> both ignored; start one cycle after done -> a new search with list_clear.
